// File: rtl/ipd_pkg.sv
// Shared move encoding, referee state encoding and default payoffs for the
// iterated prisoner's dilemma match controller.
package ipd_pkg;

   localparam logic MV_COOP   = 1'b0;
   localparam logic MV_DEFECT = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_SAMPLE,
      ST_SCORE,
      ST_DONE
   } ipd_state_t;

   localparam int DEF_PAY_T = 5;
   localparam int DEF_PAY_R = 3;
   localparam int DEF_PAY_P = 1;
   localparam int DEF_PAY_S = 0;

endpackage

// File: rtl/ipd_payoff.sv
// Combinational payoff table: maps one round's pair of moves to the payoff
// earned by each player.
module ipd_payoff
   import ipd_pkg::*;
#(
   parameter int PAY_W = 8,
   parameter int PAY_T = DEF_PAY_T,
   parameter int PAY_R = DEF_PAY_R,
   parameter int PAY_P = DEF_PAY_P,
   parameter int PAY_S = DEF_PAY_S
) (
   input  logic             a_mv,
   input  logic             b_mv,
   output logic [PAY_W-1:0] pay_a,
   output logic [PAY_W-1:0] pay_b
);

   always_comb begin
      pay_a = '0;
      pay_b = '0;
      case ({a_mv, b_mv})
         {MV_COOP, MV_COOP}: begin
            pay_a = PAY_W'(PAY_R);
            pay_b = PAY_W'(PAY_R);
         end
         {MV_DEFECT, MV_COOP}: begin
            pay_a = PAY_W'(PAY_T);
            pay_b = PAY_W'(PAY_S);
         end
         {MV_COOP, MV_DEFECT}: begin
            pay_a = PAY_W'(PAY_S);
            pay_b = PAY_W'(PAY_T);
         end
         default: begin
            pay_a = PAY_W'(PAY_P);
            pay_b = PAY_W'(PAY_P);
         end
      endcase
   end

endmodule

// File: rtl/ipd_referee.sv
// Match controller: issues rounds to two strategy blocks, forwards moves,
// keeps saturating scores. Optional move log under macro IPD_HISTORY_EN.
module ipd_referee
   import ipd_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int SCORE_W    = 8,
   parameter int PAY_T      = DEF_PAY_T,
   parameter int PAY_R      = DEF_PAY_R,
   parameter int PAY_P      = DEF_PAY_P,
   parameter int PAY_S      = DEF_PAY_S,
   parameter int HIST_DEPTH = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              a_decision,
   input  logic                              b_decision,
   output logic                              round_start,
   output logic                              a_opp_last,
   output logic                              b_opp_last,
   output logic [SCORE_W-1:0]                score_a,
   output logic [SCORE_W-1:0]                score_b,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]   round_count,
   output logic                              busy,
   output logic                              done
`ifdef IPD_HISTORY_EN
   ,
   output logic [2*HIST_DEPTH-1:0]           move_history
`endif
);

   localparam int CNT_W = $clog2(NUM_ROUNDS + 1);

   ipd_state_t         state_q;
   logic               a_mv_q, b_mv_q;
   logic               a_opp_q, b_opp_q;
   logic               rs_q, busy_q, done_q;
   logic [SCORE_W-1:0] score_a_q, score_b_q;
   logic [SCORE_W-1:0] score_a_d, score_b_d;
   logic [SCORE_W-1:0] pay_a, pay_b;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef IPD_HISTORY_EN
   logic [2*HIST_DEPTH-1:0] hist_q;
`endif

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] x,
                                                  input logic [SCORE_W-1:0] y);
      logic [SCORE_W:0] sum;
      sum = {1'b0, x} + {1'b0, y};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

   ipd_payoff #(
      .PAY_W (SCORE_W),
      .PAY_T (PAY_T),
      .PAY_R (PAY_R),
      .PAY_P (PAY_P),
      .PAY_S (PAY_S)
   ) u_payoff (
      .a_mv  (a_mv_q),
      .b_mv  (b_mv_q),
      .pay_a (pay_a),
      .pay_b (pay_b)
   );

   assign score_a_d = sat_add(score_a_q, pay_a);
   assign score_b_d = sat_add(score_b_q, pay_b);
   assign cnt_d     = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         a_mv_q    <= MV_COOP;
         b_mv_q    <= MV_COOP;
         a_opp_q   <= MV_COOP;
         b_opp_q   <= MV_COOP;
         rs_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         score_a_q <= '0;
         score_b_q <= '0;
         cnt_q     <= '0;
`ifdef IPD_HISTORY_EN
         hist_q    <= '0;
`endif
      end else begin
         rs_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // Restarting from DONE wipes the previous match completely.
               if (start) begin
                  state_q   <= ST_ISSUE;
                  rs_q      <= 1'b1;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  a_opp_q   <= MV_COOP;
                  b_opp_q   <= MV_COOP;
                  score_a_q <= '0;
                  score_b_q <= '0;
                  cnt_q     <= '0;
`ifdef IPD_HISTORY_EN
                  hist_q    <= '0;
`endif
               end
            end
            ST_ISSUE: begin
               state_q <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               // Strategies registered these on the ISSUE edge.
               a_mv_q  <= a_decision;
               b_mv_q  <= b_decision;
               state_q <= ST_SCORE;
            end
            ST_SCORE: begin
               score_a_q <= score_a_d;
               score_b_q <= score_b_d;
               a_opp_q   <= b_mv_q;
               b_opp_q   <= a_mv_q;
               cnt_q     <= cnt_d;
`ifdef IPD_HISTORY_EN
               hist_q    <= {hist_q[2*HIST_DEPTH-3:0], a_mv_q, b_mv_q};
`endif
               if (cnt_d == CNT_W'(NUM_ROUNDS)) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_ISSUE;
                  rs_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign round_start = rs_q;
   assign a_opp_last  = a_opp_q;
   assign b_opp_last  = b_opp_q;
   assign score_a     = score_a_q;
   assign score_b     = score_b_q;
   assign round_count = cnt_q;
   assign busy        = busy_q;
   assign done        = done_q;
`ifdef IPD_HISTORY_EN
   assign move_history = hist_q;
`endif

endmodule

// File: tb/tb_ipd_referee.sv
// Bench for ipd_referee: stub strategy players, a round-level reference model
// built from logged moves, and three DUT configurations exercised in turn.
module tb_ipd_referee;

   logic clk = 1'b0;
   logic reset, start, new_match;
   int   sel, mode_a, mode_b;
   int   total = 0;
   int   bad   = 0;

   logic a_dec = 1'b0, b_dec = 1'b0;
   logic ga = 1'b0, gb = 1'b0;
   int   rnd = 0;
   bit   qa[$];
   bit   qb[$];
   bit   ra[64];
   bit   rb[64];

   logic start0, start1, start2;
   logic rs0, rs1, rs2, aol0, aol1, aol2, bol0, bol1, bol2;
   logic busy0, busy1, busy2, done0, done1, done2;
   logic [7:0] sa0, sb0, sa2, sb2;
   logic [5:0] sa1, sb1;
   logic [3:0] cnt0;
   logic [4:0] cnt1;
   logic [0:0] cnt2;
`ifdef IPD_HISTORY_EN
   logic [7:0]  hist0;
   logic [15:0] hist1, hist2;
`endif

   logic        rs_m, aol_m, bol_m, busy_m, done_m;
   logic [31:0] sa_m, sb_m, cnt_m;

   always #5 clk = ~clk;

   assign start0 = start && (sel == 0);
   assign start1 = start && (sel == 1);
   assign start2 = start && (sel == 2);

   ipd_referee #(.HIST_DEPTH(4)) u_main (
      .clk(clk), .reset(reset), .start(start0),
      .a_decision(a_dec), .b_decision(b_dec),
      .round_start(rs0), .a_opp_last(aol0), .b_opp_last(bol0),
      .score_a(sa0), .score_b(sb0), .round_count(cnt0),
      .busy(busy0), .done(done0)
`ifdef IPD_HISTORY_EN
      , .move_history(hist0)
`endif
   );

   ipd_referee #(.NUM_ROUNDS(20), .SCORE_W(6)) u_sat (
      .clk(clk), .reset(reset), .start(start1),
      .a_decision(a_dec), .b_decision(b_dec),
      .round_start(rs1), .a_opp_last(aol1), .b_opp_last(bol1),
      .score_a(sa1), .score_b(sb1), .round_count(cnt1),
      .busy(busy1), .done(done1)
`ifdef IPD_HISTORY_EN
      , .move_history(hist1)
`endif
   );

   ipd_referee #(.NUM_ROUNDS(1)) u_one (
      .clk(clk), .reset(reset), .start(start2),
      .a_decision(a_dec), .b_decision(b_dec),
      .round_start(rs2), .a_opp_last(aol2), .b_opp_last(bol2),
      .score_a(sa2), .score_b(sb2), .round_count(cnt2),
      .busy(busy2), .done(done2)
`ifdef IPD_HISTORY_EN
      , .move_history(hist2)
`endif
   );

   always_comb begin
      rs_m = rs0; aol_m = aol0; bol_m = bol0; busy_m = busy0; done_m = done0;
      sa_m = 32'(sa0); sb_m = 32'(sb0); cnt_m = 32'(cnt0);
      case (sel)
         1: begin
            rs_m = rs1; aol_m = aol1; bol_m = bol1; busy_m = busy1; done_m = done1;
            sa_m = 32'(sa1); sb_m = 32'(sb1); cnt_m = 32'(cnt1);
         end
         2: begin
            rs_m = rs2; aol_m = aol2; bol_m = bol2; busy_m = busy2; done_m = done2;
            sa_m = 32'(sa2); sb_m = 32'(sb2); cnt_m = 32'(cnt2);
         end
         default: ;
      endcase
   end

   // Strategy modes: 0 coop, 1 defect, 2 D,C,.., 3 C,D,D,C,.., 4 grudger, 5 random
   function automatic logic pick(input int mode, input int r, input logic opp,
                                 input logic gr, input bit rbit);
      case (mode)
         0: return 1'b0;
         1: return 1'b1;
         2: return (r % 2) == 0;
         3: return ((r % 4) == 1) || ((r % 4) == 2);
         4: return gr | opp;
         default: return rbit;
      endcase
   endfunction

   always @(posedge clk) begin
      if (new_match) begin
         rnd <= 0;
         ga  <= 1'b0;
         gb  <= 1'b0;
         qa.delete();
         qb.delete();
      end else if (rs_m) begin
         a_dec <= pick(mode_a, rnd, aol_m, ga, ra[rnd % 64]);
         b_dec <= pick(mode_b, rnd, bol_m, gb, rb[rnd % 64]);
         qa.push_back(pick(mode_a, rnd, aol_m, ga, ra[rnd % 64]));
         qb.push_back(pick(mode_b, rnd, bol_m, gb, rb[rnd % 64]));
         if (mode_a == 4) ga <= ga | aol_m;
         if (mode_b == 4) gb <= gb | bol_m;
         rnd <= rnd + 1;
      end
   end

   function automatic int pay(input bit me, input bit other);
      if (!me && !other) return 3;
      if (me && !other)  return 5;
      if (!me && other)  return 0;
      return 1;
   endfunction

   function automatic int exp_score(input int r, input bit for_a, input int mx);
      int s = 0;
      for (int i = 0; i < r; i++)
         s += for_a ? pay(qa[i], qb[i]) : pay(qb[i], qa[i]);
      return (s > mx) ? mx : s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".rs"}, 32'(rs_m), 0);
      chk({tag, ".busy"}, 32'(busy_m), 0);
      chk({tag, ".done"}, 32'(done_m), 0);
      chk({tag, ".aol"}, 32'(aol_m), 0);
      chk({tag, ".bol"}, 32'(bol_m), 0);
      chk({tag, ".sa"}, sa_m, 0);
      chk({tag, ".sb"}, sb_m, 0);
      chk({tag, ".cnt"}, cnt_m, 0);
   endtask

   // Start a match on DUT s and check it cycle by cycle; optional start poke
   // while busy and optional reset abort at cycle abort_j after the start edge.
   task automatic run_match(input int s, input int n, input int mx, input int ma,
                            input int mb, input int poke, input int abort_j);
      int pulses = 0;
      int r;
      sel = s; mode_a = ma; mode_b = mb;
      @(negedge clk); start = 1'b1; new_match = 1'b1;
      @(negedge clk); start = 1'b0; new_match = 1'b0;
      for (int j = 1; j <= 3 * n + 2; j++) begin
         r = (j - 1) / 3;
         if (rs_m) pulses++;
         chk("round_start", 32'(rs_m), 32'((j <= 3 * n) && (j % 3 == 1)));
         chk("busy", 32'(busy_m), 32'(j <= 3 * n));
         chk("done", 32'(done_m), 32'(j > 3 * n));
         if ((j <= 3 * n) && (j % 3 == 1)) begin
            chk("count@rs", cnt_m, r);
            chk("a_opp_last", 32'(aol_m), (r == 0) ? 0 : 32'(qb[r-1]));
            chk("b_opp_last", 32'(bol_m), (r == 0) ? 0 : 32'(qa[r-1]));
            chk("score_a@rs", sa_m, exp_score(r, 1'b1, mx));
            chk("score_b@rs", sb_m, exp_score(r, 1'b0, mx));
         end
         if (j > 3 * n) begin
            chk("count@done", cnt_m, n);
            chk("score_a@done", sa_m, exp_score(n, 1'b1, mx));
            chk("score_b@done", sb_m, exp_score(n, 1'b0, mx));
         end
         if (j == abort_j) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk_zero("abort");
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               chk("abort.rs", 32'(rs_m), 0);
               chk("abort.busy", 32'(busy_m), 0);
            end
            return;
         end
         start = (j == poke);
         @(negedge clk);
      end
      start = 1'b0;
      chk("pulses", pulses, n);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         ra[i] = 1'($urandom);
         rb[i] = 1'($urandom);
      end
      reset = 1'b1; start = 1'b0; new_match = 1'b1;
      sel = 0; mode_a = 0; mode_b = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0; new_match = 1'b0;
      chk_zero("reset");
`ifdef IPD_HISTORY_EN
      chk("reset.hist", 32'(hist0), 0);
`endif

      run_match(0, 10, 255, 0, 0, 0, 0);
      chk("coop.sa", sa_m, 30);
      chk("coop.sb", sb_m, 30);
      chk("coop.cnt", cnt_m, 10);

      run_match(0, 10, 255, 1, 0, 0, 0);
      chk("dc.sa", sa_m, 50);
      chk("dc.sb", sb_m, 0);

      run_match(0, 10, 255, 1, 1, 0, 0);
      chk("dd.sa", sa_m, 10);
      chk("dd.sb", sb_m, 10);

      run_match(0, 10, 255, 4, 3, 0, 0);
      for (int i = 0; i < 10; i++)
         chk("grudger.a_move", 32'(qa[i]), 32'(i >= 2));

      run_match(0, 10, 255, 5, 5, 5, 0);
      run_match(0, 10, 255, 5, 3, 14, 0);

      run_match(0, 10, 255, 5, 5, 0, 11);
      run_match(0, 10, 255, 0, 0, 0, 0);
      chk("post_abort.sa", sa_m, 30);
      chk("post_abort.cnt", cnt_m, 10);

      run_match(1, 20, 63, 1, 0, 0, 0);
      chk("sat.sa", sa_m, 63);
      chk("sat.sb", sb_m, 0);

      // Held start on a one-round match: restart every 4 cycles.
      sel = 2; mode_a = 0; mode_b = 0;
      @(negedge clk); start = 1'b1; new_match = 1'b1;
      @(negedge clk); new_match = 1'b0;
      for (int j = 1; j <= 12; j++) begin
         chk("hold.rs", 32'(rs_m), 32'(j % 4 == 1));
         chk("hold.done", 32'(done_m), 32'(j % 4 == 0));
         chk("hold.busy", 32'(busy_m), 32'(j % 4 != 0));
         if (j % 4 == 0) begin
            chk("hold.sa", sa_m, 3);
            chk("hold.cnt", cnt_m, 1);
         end
         @(negedge clk);
      end
      start = 1'b0;

`ifdef IPD_HISTORY_EN
      begin
         logic [7:0] hexp;
         run_match(0, 10, 255, 2, 0, 0, 0);
         hexp = '0;
         for (int i = 0; i < 4; i++) begin
            hexp[2*i+1] = qa[9-i];
            hexp[2*i]   = qb[9-i];
         end
         chk("hist.model", 32'(hist0), 32'(hexp));
         chk("hist.const", 32'(hist0), 32'h88);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ipd_referee.md
# ipd_referee

Match controller for the iterated prisoner's dilemma. It is the initiator side of the strategy interface: it pulses `round_start` to two strategy blocks (players A and B), samples their registered decisions, and forwards each player's move to the other as `opponent_last_move`. It also accumulates saturating payoff scores and signals match completion to the top-level display/FSM.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: rounds per match; must be ≥1.
- `SCORE_W`, default 8: width of each score accumulator.
- `PAY_T`, `PAY_R`, `PAY_P`, `PAY_S`, defaults 5 / 3 / 1 / 0: payoffs for temptation, reward, punishment and sucker.
- `HIST_DEPTH`, default 8: rounds kept in the history log (only used with `IPD_HISTORY_EN`).

Ports:
- `clk` input 1: the only clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a match; sampled in IDLE or DONE only.
- `a_decision` input 1: player A's move (1 = defect, 0 = cooperate).
- `b_decision` input 1: player B's move.
- `round_start` output 1: one-cycle pulse to both strategies.
- `a_opp_last` output 1: B's previous move, wired to A's `opponent_last_move`.
- `b_opp_last` output 1: A's previous move, wired to B's `opponent_last_move`.
- `score_a` output `SCORE_W`: A's accumulated payoff.
- `score_b` output `SCORE_W`: B's accumulated payoff.
- `round_count` output `$clog2(NUM_ROUNDS+1)`: rounds completed.
- `busy` output 1: match in progress.
- `done` output 1: match complete, level.
- `move_history` output `2*HIST_DEPTH`: present only with `IPD_HISTORY_EN`.

## Operation
- States: IDLE, ISSUE, SAMPLE, SCORE, DONE.
- IDLE
  - `busy`=0, `done`=0.
  - `start`=1 clears scores, `round_count`, both opp_last regs and the history log, then goes to ISSUE.
- ISSUE
  - `round_start`=1 for exactly this cycle.
  - Strategies register their decision on this edge.
  - Next state: SAMPLE.
- SAMPLE
  - `a_decision` and `b_decision` are captured into internal `a_mv` and `b_mv`.
  - These are the values the strategies registered at the ISSUE edge.
  - Next state: SCORE.
- SCORE
  - Payoff by (`a_mv`, `b_mv`): (0,0) gives R,R; (1,0) gives T,S; (0,1) gives S,T; (1,1) gives P,P.
  - Each score adds its payoff, saturating at 2^SCORE_W−1 with no wrap.
  - `a_opp_last` ← `b_mv`, `b_opp_last` ← `a_mv`.
  - `round_count` increments.
  - If the new count equals NUM_ROUNDS, go to DONE; otherwise go to ISSUE.
- DONE
  - `done`=1 and `busy`=0.
  - Scores and `round_count` are held.
  - `start`=1 clears state and goes to ISSUE, exactly as from IDLE.
- `busy`=1 in ISSUE, SAMPLE and SCORE.
- `start` is ignored while `busy`.
- Round 1: both opp_last outputs are 0 (cooperate) when `round_start` fires.
- Inputs `a_decision` and `b_decision` are don't-care outside SAMPLE.

## Timing
- Reset values: all outputs 0, state IDLE. Reset overrides every other input in any state and aborts a match mid-round without a further `round_start`.
- Latency:
  - `start` sampled at edge k → `round_start` high in cycle k+1.
  - Each round takes 3 cycles.
  - The `round_start` pulses are 3 cycles apart.
  - `done` rises 3·NUM_ROUNDS+1 cycles after the `start` edge.
- Score, count and opp_last values update on the SCORE exit edge, so they are stable during the next ISSUE cycle.
- NUM_ROUNDS=1: ISSUE → SAMPLE → SCORE → DONE.
- `start` held high continuously restarts a match on the cycle after DONE is entered.

## Configuration
- Macro `IPD_HISTORY_EN`.
- Defined:
  - `move_history` is a shift register updated in SCORE: `{history[2*HIST_DEPTH-3:0], a_mv, b_mv}`.
  - The newest pair is in bits [1:0].
  - It is cleared on reset and on `start`.
- Undefined: the port and the register are absent, and all other behaviour is identical.

## Structure
- Package `ipd_pkg` holds:
  - the move encoding localparams `MV_COOP=0` and `MV_DEFECT=1`;
  - the state enum `ipd_state_t`;
  - the default payoff constants.
- Sub-module `ipd_payoff`: purely combinational. It maps (`a_mv`, `b_mv`) to (`pay_a`, `pay_b`) using the payoff parameters.
- Saturating add, FSM and forwarding live in `ipd_referee`.

## Test plan
- Two stub players, always cooperate, NUM_ROUNDS=10:
  - `score_a`=30, `score_b`=30;
  - `round_count`=10, `done`=1 at cycle 31 after start;
  - exactly 10 `round_start` pulses.
- A always defects, B always cooperates → `score_a`=50, `score_b`=0. Mutual defection → 10/10.
- B plays the pattern C,D,D,C,… with A a grudger:
  - `a_opp_last` at each `round_start` equals B's move from the previous round;
  - it is 0 at round 1;
  - A's decision sticks at 1 from round 3.
- SCORE_W=6, NUM_ROUNDS=20, A always defects vs B cooperating → `score_a` saturates at 63, not 36.
- `reset` asserted in SAMPLE of round 4:
  - all outputs 0 next cycle, no further `round_start`;
  - a subsequent `start` runs a clean 10-round match.
- With `IPD_HISTORY_EN`, HIST_DEPTH=4, A pattern D,C,D,C and B all C → `move_history`=8'b10_00_10_00. The bench also checks that `start` is ignored while `busy`.
